skin_box_ctrl: RTL and testbench
================================

Name: skin_box_ctrl

Overview:
- Frame-level controller for the skin-colour detection pipeline.
- Owns the four Cb/Cr window thresholds and commits them only at frame boundaries.
- Aligns pixel coordinates to the 4-cycle mask latency, accumulates the mask's bounding box and pixel count per frame, and publishes one result per frame.
- Sits between the camera timing signals, the RGB565→YCbCr mask stage, and the downstream box overlay/UART reporter.

Parameters:
- IMG_W, 640: active pixels per line.
- IMG_H, 480: active lines per frame.
- MASK_LAT, 4: cycles from frame_clken to the matching mask_in.
- MIN_PIX, 64: minimum mask count for box_found=1.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; synchronous, active-high (1 = reset; the _n name is kept for uniformity with sibling blocks)
- frame_vsync  in  1  frame sync, high between frames
- frame_href  in  1  line active
- frame_clken  in  1  pixel valid
- mask_in  in  1  skin mask from detector, MASK_LAT cycles behind frame_clken
- cfg_we  in  1  threshold write strobe
- cfg_addr  in  2  0=cb_lo 1=cb_hi 2=cr_lo 3=cr_hi
- cfg_wdata  in  8  threshold value
- thr_cb_lo, thr_cb_hi, thr_cr_lo, thr_cr_hi  out  8 each  active thresholds to the detector
- box_x0, box_x1  out  10 each  published left/right column
- box_y0, box_y1  out  9 each  published top/bottom line
- pix_cnt  out  19  published mask pixel count
- box_found  out  1  pix_cnt >= MIN_PIX
- box_valid  out  1  one-cycle pulse when a new result is published
- busy  out  1  FSM in ACTIVE

Behaviour:
- Reset values:
  - thresholds (active and shadow): 100/140/130/160.
  - box_*, pix_cnt, box_found, box_valid, busy: 0.
  - FSM: IDLE.
- Alignment: frame_href and frame_clken are delayed MASK_LAT cycles (dh, dc). All counting uses dh/dc, so mask_in pairs with the correct x,y.
- Coordinates:
  - x increments on each dc while dh=1, and clears on the dh falling edge.
  - y increments on the dh falling edge and clears in IDLE.
  - Pixels with x>=IMG_W or y>=IMG_H are ignored; counters saturate at all-ones.
- FSM:
  - IDLE → ARMED on frame_vsync=1.
  - ARMED → ACTIVE on the vsync falling edge. On entry: clear accumulators; min_x=IMG_W-1, max_x=0, min_y=IMG_H-1, max_y=0, cnt=0.
  - ACTIVE → PUBLISH on the vsync rising edge, which also ends a truncated frame.
  - PUBLISH (1 cycle) → ARMED.
- Accumulate: in ACTIVE, each dc&dh&mask_in cycle updates min/max x/y and cnt. cnt saturates at 2^19-1.
- PUBLISH cycle:
  - box_* <= min/max, pix_cnt <= cnt, box_found <= (cnt>=MIN_PIX).
  - box_valid=1 for that cycle only.
  - Active thresholds <= shadow.
  - If cnt==0, box outputs = 0.
- Latency: box_valid rises 2 cycles after the frame_vsync rising edge (edge detect + PUBLISH register).
- Config:
  - cfg_we writes the shadow register only; it is accepted in any state.
  - A write in the PUBLISH cycle is not committed until the next frame.
  - While in IDLE (before the first vsync), a write commits to the active thresholds the next cycle.
  - lo>hi is legal: the detector then never fires.
- rst_n mid-frame: everything returns to reset values next cycle and no box_valid is issued. The first frame after reset is skipped (ARMED needs a vsync first).

Optional Feature:
- Macro: SKIN_BOX_OVERLAY_EN.
- With the macro defined: adds output box_edge (1). It is registered and aligned to dc. It is 1 when box_found=1 and the current (x,y) lies on the border of the last published box (x∈{x0,x1} with y0≤y≤y1, or y∈{y0,y1} with x0≤x≤x1).
- Without it: the port is absent and the logic is removed.

Decomposition:
- skin_box_pkg:
  - FSM state enum (IDLE, ARMED, ACTIVE, PUBLISH).
  - cfg address constants.
  - default thresholds (100, 140, 130, 160).
  - coordinate widths.
- Sub-module skin_box_align: MASK_LAT-deep delay line for href/clken with a falling-edge detect.

Test Plan:
- Reset, then read thresholds → 100/140/130/160. box_valid stays 0 through the first frame.
- Second frame, 640x480, mask=1 exactly at x 100..199, y 50..149 → one box_valid pulse with x0=100 x1=199 y0=50 y1=149, pix_cnt=10000, box_found=1.
- Frame with mask only at (5,5) → box 5/5/5/5, pix_cnt=1, box_found=0. All-zero frame → box=0, pix_cnt=0, box_found=0.
- cfg write addr0=90 mid-frame → thr_cb_lo stays 100 until the PUBLISH cycle, then becomes 90. A write in the PUBLISH cycle appears only after the next frame.
- mask_in driven 1 on the cycle one before the aligned pixel (x=99) → must not extend the box (x0 stays 100).
- vsync raised mid-frame at line 200 → publish with partial data. rst_n at line 100 → outputs 0, no box_valid for that frame.

Source files
------------

// File: rtl/skin_box_pkg.sv
// Shared types and constants for the skin-colour box controller.
// Overlay output is enabled by defining SKIN_BOX_OVERLAY_EN.
package skin_box_pkg;

    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int CNT_W = 19;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_PUBLISH = 2'd3
    } state_t;

    localparam logic [1:0] CFG_CB_LO = 2'd0;
    localparam logic [1:0] CFG_CB_HI = 2'd1;
    localparam logic [1:0] CFG_CR_LO = 2'd2;
    localparam logic [1:0] CFG_CR_HI = 2'd3;

    localparam logic [7:0] DEF_CB_LO = 8'd100;
    localparam logic [7:0] DEF_CB_HI = 8'd140;
    localparam logic [7:0] DEF_CR_LO = 8'd130;
    localparam logic [7:0] DEF_CR_HI = 8'd160;

    function automatic logic [7:0] thr_default(input logic [1:0] addr);
        logic [7:0] val;
        case (addr)
            CFG_CB_LO: val = DEF_CB_LO;
            CFG_CB_HI: val = DEF_CB_HI;
            CFG_CR_LO: val = DEF_CR_LO;
            default:   val = DEF_CR_HI;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/skin_box_align.sv
// Delays href/clken by the mask latency so counting pairs with mask_in;
// also flags the falling edge of the delayed href (end of line).
module skin_box_align #(
    parameter int LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic href,
    input  logic clken,
    output logic dh,
    output logic dc,
    output logic dh_fall
);
    logic [LAT-1:0] href_sr_reg;
    logic [LAT-1:0] clken_sr_reg;
    logic [LAT-1:0] href_sr_next;
    logic [LAT-1:0] clken_sr_next;
    logic           dh_prev_reg;

    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign href_sr_next[gi]  = href;
                assign clken_sr_next[gi] = clken;
            end else begin : g_next
                assign href_sr_next[gi]  = href_sr_reg[gi-1];
                assign clken_sr_next[gi] = clken_sr_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst_n) begin
            href_sr_reg  <= '0;
            clken_sr_reg <= '0;
            dh_prev_reg  <= 1'b0;
        end else begin
            href_sr_reg  <= href_sr_next;
            clken_sr_reg <= clken_sr_next;
            dh_prev_reg  <= href_sr_reg[LAT-1];
        end
    end

    assign dh      = href_sr_reg[LAT-1];
    assign dc      = clken_sr_reg[LAT-1];
    assign dh_fall = dh_prev_reg & ~href_sr_reg[LAT-1];

endmodule

// File: rtl/skin_box_ctrl.sv
// Frame controller: threshold shadowing, mask bounding box and count per frame.
// Define SKIN_BOX_OVERLAY_EN to add the registered box_edge overlay output.
module skin_box_ctrl
    import skin_box_pkg::*;
#(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int MASK_LAT = 4,
    parameter int MIN_PIX  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_vsync,
    input  logic             frame_href,
    input  logic             frame_clken,
    input  logic             mask_in,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [7:0]       cfg_wdata,
    output logic [7:0]       thr_cb_lo,
    output logic [7:0]       thr_cb_hi,
    output logic [7:0]       thr_cr_lo,
    output logic [7:0]       thr_cr_hi,
    output logic [X_W-1:0]   box_x0,
    output logic [X_W-1:0]   box_x1,
    output logic [Y_W-1:0]   box_y0,
    output logic [Y_W-1:0]   box_y1,
    output logic [CNT_W-1:0] pix_cnt,
    output logic             box_found,
    output logic             box_valid,
`ifdef SKIN_BOX_OVERLAY_EN
    output logic             box_edge,
`endif
    output logic             busy
);
    localparam logic [X_W-1:0]   X_LIM   = X_W'(IMG_W);
    localparam logic [X_W-1:0]   X_LAST  = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]   Y_LIM   = Y_W'(IMG_H);
    localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PIX);

    logic dh, dc, dh_fall;
    logic vs_prev_reg, vs_rise, vs_fall;
    state_t state_reg, state_next;
    logic do_clear, do_accum, do_publish, thr_load;

    logic [X_W-1:0]   x_reg, min_x_reg, max_x_reg;
    logic [Y_W-1:0]   y_reg, min_y_reg, max_y_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             pix_hit;

    logic [X_W-1:0]   box_x0_reg, box_x1_reg;
    logic [Y_W-1:0]   box_y0_reg, box_y1_reg;
    logic [CNT_W-1:0] pix_cnt_reg;
    logic             box_found_reg, box_valid_reg;

    logic [7:0] thr_shadow_reg [4];
    logic [7:0] thr_active_reg [4];

    skin_box_align #(.LAT(MASK_LAT)) u_align (
        .clk     (clk),
        .rst_n   (rst_n),
        .href    (frame_href),
        .clken   (frame_clken),
        .dh      (dh),
        .dc      (dc),
        .dh_fall (dh_fall)
    );

    always_ff @(posedge clk) begin
        if (rst_n) vs_prev_reg <= 1'b0;
        else       vs_prev_reg <= frame_vsync;
    end
    assign vs_rise = frame_vsync & ~vs_prev_reg;
    assign vs_fall = ~frame_vsync & vs_prev_reg;

    always_ff @(posedge clk) begin
        if (rst_n) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (frame_vsync) state_next = ST_ARMED;
            ST_ARMED:   if (vs_fall)     state_next = ST_ACTIVE;
            ST_ACTIVE:  if (vs_rise)     state_next = ST_PUBLISH;
            ST_PUBLISH:                  state_next = ST_ARMED;
            default:                     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        do_clear   = 1'b0;
        do_accum   = 1'b0;
        do_publish = 1'b0;
        thr_load   = 1'b0;
        case (state_reg)
            ST_IDLE:    thr_load = 1'b1;
            ST_ARMED:   do_clear = vs_fall;
            ST_ACTIVE:  begin busy = 1'b1; do_accum = 1'b1; end
            ST_PUBLISH: begin do_publish = 1'b1; thr_load = 1'b1; end
            default:    ;
        endcase
    end

    // Coordinates only advance inside a frame; everywhere else they sit at origin.
    always_ff @(posedge clk) begin
        if (rst_n || state_reg != ST_ACTIVE) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (dh_fall) begin
            x_reg <= '0;
            if (y_reg != '1) y_reg <= y_reg + 1'b1;
        end else if (dc && dh) begin
            if (x_reg != '1) x_reg <= x_reg + 1'b1;
        end
    end

    assign pix_hit = do_accum & dc & dh & mask_in & (x_reg < X_LIM) & (y_reg < Y_LIM);

    always_ff @(posedge clk) begin
        if (rst_n || do_clear) begin
            min_x_reg <= X_LAST;
            max_x_reg <= '0;
            min_y_reg <= Y_LAST;
            max_y_reg <= '0;
            cnt_reg   <= '0;
        end else if (pix_hit) begin
            if (x_reg < min_x_reg) min_x_reg <= x_reg;
            if (x_reg > max_x_reg) max_x_reg <= x_reg;
            if (y_reg < min_y_reg) min_y_reg <= y_reg;
            if (y_reg > max_y_reg) max_y_reg <= y_reg;
            if (cnt_reg != '1)     cnt_reg   <= cnt_reg + 1'b1;
        end
    end

    // An empty frame publishes an all-zero box rather than the init sentinels.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            box_x0_reg    <= '0;
            box_x1_reg    <= '0;
            box_y0_reg    <= '0;
            box_y1_reg    <= '0;
            pix_cnt_reg   <= '0;
            box_found_reg <= 1'b0;
            box_valid_reg <= 1'b0;
        end else begin
            box_valid_reg <= do_publish;
            if (do_publish) begin
                box_x0_reg    <= (cnt_reg == '0) ? '0 : min_x_reg;
                box_x1_reg    <= (cnt_reg == '0) ? '0 : max_x_reg;
                box_y0_reg    <= (cnt_reg == '0) ? '0 : min_y_reg;
                box_y1_reg    <= (cnt_reg == '0) ? '0 : max_y_reg;
                pix_cnt_reg   <= cnt_reg;
                box_found_reg <= (cnt_reg >= CNT_MIN);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_thr
            always_ff @(posedge clk) begin
                if (rst_n) begin
                    thr_shadow_reg[gi] <= thr_default(2'(gi));
                    thr_active_reg[gi] <= thr_default(2'(gi));
                end else begin
                    if (cfg_we && cfg_addr == 2'(gi)) thr_shadow_reg[gi] <= cfg_wdata;
                    if (thr_load)                     thr_active_reg[gi] <= thr_shadow_reg[gi];
                end
            end
        end
    endgenerate

    assign thr_cb_lo = thr_active_reg[CFG_CB_LO];
    assign thr_cb_hi = thr_active_reg[CFG_CB_HI];
    assign thr_cr_lo = thr_active_reg[CFG_CR_LO];
    assign thr_cr_hi = thr_active_reg[CFG_CR_HI];

    assign box_x0    = box_x0_reg;
    assign box_x1    = box_x1_reg;
    assign box_y0    = box_y0_reg;
    assign box_y1    = box_y1_reg;
    assign pix_cnt   = pix_cnt_reg;
    assign box_found = box_found_reg;
    assign box_valid = box_valid_reg;

`ifdef SKIN_BOX_OVERLAY_EN
    logic box_edge_reg;
    logic on_col, on_row;
    assign on_col = (x_reg == box_x0_reg || x_reg == box_x1_reg) &&
                    (y_reg >= box_y0_reg) && (y_reg <= box_y1_reg);
    assign on_row = (y_reg == box_y0_reg || y_reg == box_y1_reg) &&
                    (x_reg >= box_x0_reg) && (x_reg <= box_x1_reg);

    always_ff @(posedge clk) begin
        if (rst_n) box_edge_reg <= 1'b0;
        else       box_edge_reg <= dc & dh & box_found_reg & (on_col | on_row);
    end
    assign box_edge = box_edge_reg;
`endif

endmodule

// File: tb/tb_skin_box_ctrl.sv
// Directed bench for skin_box_ctrl on a reduced 32x24 image: frame table plus
// hand sequences for threshold commit timing and mid-frame reset.
module tb_skin_box_ctrl;

    localparam int M_BOX = 0, M_DOT = 1, M_ZERO = 2, M_CORNER = 3, M_64 = 4, M_63 = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_vsync = 1'b0, frame_href = 1'b0, frame_clken = 1'b0, mask_in = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [7:0]  cfg_wdata = 8'd0;
    logic [7:0]  thr_cb_lo, thr_cb_hi, thr_cr_lo, thr_cr_hi;
    logic [9:0]  box_x0, box_x1;
    logic [8:0]  box_y0, box_y1;
    logic [18:0] pix_cnt;
    logic        box_found, box_valid, busy;
`ifdef SKIN_BOX_OVERLAY_EN
    logic        box_edge;
`endif

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int exp_pulses = 0;
    logic [3:0] mpipe = 4'b0;

    always #5 clk = ~clk;

    skin_box_ctrl #(.IMG_W(32), .IMG_H(24), .MASK_LAT(4), .MIN_PIX(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_vsync (frame_vsync),
        .frame_href  (frame_href),
        .frame_clken (frame_clken),
        .mask_in     (mask_in),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .thr_cb_lo   (thr_cb_lo),
        .thr_cb_hi   (thr_cb_hi),
        .thr_cr_lo   (thr_cr_lo),
        .thr_cr_hi   (thr_cr_hi),
        .box_x0      (box_x0),
        .box_x1      (box_x1),
        .box_y0      (box_y0),
        .box_y1      (box_y1),
        .pix_cnt     (pix_cnt),
        .box_found   (box_found),
        .box_valid   (box_valid),
`ifdef SKIN_BOX_OVERLAY_EN
        .box_edge    (box_edge),
`endif
        .busy        (busy)
    );

    always @(negedge clk) if (box_valid === 1'b1) pulses++;

    typedef struct {
        int mode; int nl; int len; bit gap;
        int x0; int x1; int y0; int y1; int cnt; bit found;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit mask_fn(input int mode, input int x, input int y);
        case (mode)
            M_BOX:    return (x >= 10 && x <= 19 && y >= 5 && y <= 14) ||
                             (x == 33 && y == 7) || (y == 25 && x == 3);
            M_DOT:    return (x == 5 && y == 5);
            M_CORNER: return (x == 0 && y == 0) || (x == 31 && y == 23);
            M_64:     return (x < 8 && y < 8);
            M_63:     return (x < 8 && y < 8) && !(x == 7 && y == 7);
            default:  return 1'b0;
        endcase
    endfunction

    // mask_in is presented 4 cycles after the clken it belongs to
    task automatic step(input logic vs, input logic hr, input logic ce, input logic mk);
        frame_vsync = vs;
        frame_href  = hr;
        frame_clken = ce;
        mask_in     = mpipe[3];
        mpipe       = {mpipe[2:0], mk};
        @(posedge clk);
        #1;
    endtask

    // gap=1 inserts an invalid cycle before each pixel; a stray mask sits in
    // the invalid slot right before x=10 and must be ignored
    task automatic lines(input int mode, input int y_first, input int n, input int len, input bit gap);
        for (int ly = 0; ly < n; ly++) begin
            for (int x = 0; x < len; x++) begin
                if (gap) step(1'b0, 1'b1, 1'b0,
                              (x == 10 && y_first + ly >= 5 && y_first + ly <= 14));
                step(1'b0, 1'b1, 1'b1, mask_fn(mode, x, y_first + ly));
            end
            for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic vsync_pulse(input bit wr_pub, output logic [5:0] bv,
                               output logic [7:0] thr0, output logic [7:0] thr1);
        bv = '0;
        thr0 = '0;
        thr1 = '0;
        for (int i = 0; i < 6; i++) begin
            cfg_we    = (wr_pub && i == 1);
            cfg_addr  = 2'd0;
            cfg_wdata = 8'd77;
            step(1'b1, 1'b0, 1'b0, 1'b0);
            bv[i] = box_valid;
            if (i == 0) thr0 = thr_cb_lo;
            if (i == 1) thr1 = thr_cb_lo;
        end
        cfg_we = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_pub(input string tag, input logic [5:0] bv, input int x0, input int x1,
                           input int y0, input int y1, input int cnt, input bit found);
        chk({tag, "_valid_timing"}, 32'(bv), 32'h2);
        chk({tag, "_x0"}, 32'(box_x0), x0);
        chk({tag, "_x1"}, 32'(box_x1), x1);
        chk({tag, "_y0"}, 32'(box_y0), y0);
        chk({tag, "_y1"}, 32'(box_y1), y1);
        chk({tag, "_cnt"}, 32'(pix_cnt), cnt);
        chk({tag, "_found"}, 32'(box_found), 32'(found));
        exp_pulses++;
        $display("%s: box x=%0d..%0d y=%0d..%0d cnt=%0d found=%0d", tag,
                 box_x0, box_x1, box_y0, box_y1, pix_cnt, box_found);
    endtask

    initial begin
        logic [5:0] bv;
        logic [7:0] t0, t1;

        vecs[0] = '{M_BOX,    26, 36, 1'b0, 10, 19, 5, 14, 100, 1'b1};
        vecs[1] = '{M_DOT,    24, 32, 1'b0,  5,  5, 5,  5,   1, 1'b0};
        vecs[2] = '{M_ZERO,   24, 32, 1'b0,  0,  0, 0,  0,   0, 1'b0};
        vecs[3] = '{M_CORNER, 24, 32, 1'b0,  0, 31, 0, 23,   2, 1'b0};
        vecs[4] = '{M_64,     24, 32, 1'b0,  0,  7, 0,  7,  64, 1'b1};
        vecs[5] = '{M_63,     24, 32, 1'b0,  0,  7, 0,  7,  63, 1'b0};
        vecs[6] = '{M_BOX,    26, 36, 1'b1, 10, 19, 5, 14, 100, 1'b1};
        vecs[7] = '{M_BOX,     8, 36, 1'b0, 10, 19, 5,  7,  30, 1'b0};

        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_thr_cb_lo", 32'(thr_cb_lo), 100);
        chk("rst_thr_cb_hi", 32'(thr_cb_hi), 140);
        chk("rst_thr_cr_lo", 32'(thr_cr_lo), 130);
        chk("rst_thr_cr_hi", 32'(thr_cr_hi), 160);
        chk("rst_box", 32'({box_x0, box_x1} | 20'({box_y0, box_y1})), 0);
        chk("rst_cnt", 32'(pix_cnt), 0);
        chk("rst_flags", 32'({box_found, box_valid, busy}), 0);
        $display("reset: thr=%0d/%0d/%0d/%0d", thr_cb_lo, thr_cb_hi, thr_cr_lo, thr_cr_hi);

        // first frame after reset has no leading vsync and is never published
        lines(M_BOX, 0, 26, 36, 1'b0);
        chk("idle_busy", 32'(busy), 0);
        vsync_pulse(1'b0, bv, t0, t1);
        chk("skip_frame_valid", 32'(bv), 0);
        chk("armed_to_active_busy", 32'(busy), 1);
        $display("frame skipped after reset: valid_hist=%b", bv);

        for (int i = 0; i < 8; i++) begin
            lines(vecs[i].mode, 0, vecs[i].nl, vecs[i].len, vecs[i].gap);
            vsync_pulse(1'b0, bv, t0, t1);
            chk_pub($sformatf("vec%0d", i), bv, vecs[i].x0, vecs[i].x1, vecs[i].y0,
                    vecs[i].y1, vecs[i].cnt, vecs[i].found);
        end

        // mid-frame write commits at PUBLISH; a PUBLISH-cycle write waits a frame
        lines(M_DOT, 0, 12, 32, 1'b0);
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 8'd90;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        cfg_we = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("midframe_thr_hold", 32'(thr_cb_lo), 100);
        lines(M_DOT, 12, 12, 32, 1'b0);
        vsync_pulse(1'b1, bv, t0, t1);
        chk("thr_before_publish", 32'(t0), 100);
        chk("thr_at_publish", 32'(t1), 90);
        chk_pub("cfg_frame", bv, 5, 5, 5, 5, 1, 1'b0);
        lines(M_ZERO, 0, 24, 32, 1'b0);
        chk("publish_write_deferred", 32'(thr_cb_lo), 90);
        vsync_pulse(1'b0, bv, t0, t1);
        chk("publish_write_later", 32'(t1), 77);
        chk_pub("zero_frame", bv, 0, 0, 0, 0, 0, 1'b0);

        // reset in the middle of a frame
        lines(M_DOT, 0, 24, 32, 1'b0);
        vsync_pulse(1'b0, bv, t0, t1);
        chk_pub("pre_reset", bv, 5, 5, 5, 5, 1, 1'b0);
        lines(M_BOX, 0, 10, 36, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        chk("midrst_x0", 32'(box_x0), 0);
        chk("midrst_cnt", 32'(pix_cnt), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_thr_cb_lo", 32'(thr_cb_lo), 100);
        $display("mid-frame reset: x0=%0d cnt=%0d thr_cb_lo=%0d", box_x0, pix_cnt, thr_cb_lo);
        cfg_we = 1'b1; cfg_addr = 2'd3; cfg_wdata = 8'd200;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        cfg_we = 1'b0;
        chk("idle_write_not_yet", 32'(thr_cr_hi), 160);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_write_commit", 32'(thr_cr_hi), 200);
        lines(M_BOX, 10, 16, 36, 1'b0);
        vsync_pulse(1'b0, bv, t0, t1);
        chk("midrst_no_valid", 32'(bv), 0);
        lines(M_DOT, 0, 24, 32, 1'b0);
        vsync_pulse(1'b0, bv, t0, t1);
        chk_pub("post_reset", bv, 5, 5, 5, 5, 1, 1'b0);

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("valid_pulse_count", 32'(pulses), 32'(exp_pulses));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
